// File: rtl/smi_frame_wrr_scheduler_x4_if.sv
// ---------------------------------------------------------------------------
// smi_frame_wrr_scheduler_x4_if
// Bundles every non-clock/reset signal of the four-port SMI weighted
// round-robin frame scheduler.
//   weightA..D             : frames per grant for each input port
//   smiInX{Ready,Eofc,Data}: input port X flit (X = A..D)
//   smiInXStop             : backpressure towards input port X
//   smiOut{Ready,Eofc,Data}: shared output flit
//   smiOutStop             : backpressure from the output consumer
//   grantValid/grantPort   : current grant owner
// Modports: master = upstream producers plus downstream consumer side,
//           slave  = the scheduler itself.
// ---------------------------------------------------------------------------
interface smi_frame_wrr_scheduler_x4_if #(
  parameter int FlitWidth   = 2,
  parameter int WeightWidth = 4
);
  logic [WeightWidth-1:0] weightA;
  logic [WeightWidth-1:0] weightB;
  logic [WeightWidth-1:0] weightC;
  logic [WeightWidth-1:0] weightD;

  logic                   smiInAReady;
  logic [7:0]             smiInAEofc;
  logic [FlitWidth*8-1:0] smiInAData;
  logic                   smiInAStop;
  logic                   smiInBReady;
  logic [7:0]             smiInBEofc;
  logic [FlitWidth*8-1:0] smiInBData;
  logic                   smiInBStop;
  logic                   smiInCReady;
  logic [7:0]             smiInCEofc;
  logic [FlitWidth*8-1:0] smiInCData;
  logic                   smiInCStop;
  logic                   smiInDReady;
  logic [7:0]             smiInDEofc;
  logic [FlitWidth*8-1:0] smiInDData;
  logic                   smiInDStop;

  logic                   smiOutReady;
  logic [7:0]             smiOutEofc;
  logic [FlitWidth*8-1:0] smiOutData;
  logic                   smiOutStop;

  logic                   grantValid;
  logic [1:0]             grantPort;

  modport master (
    output weightA, weightB, weightC, weightD,
    output smiInAReady, smiInAEofc, smiInAData, input smiInAStop,
    output smiInBReady, smiInBEofc, smiInBData, input smiInBStop,
    output smiInCReady, smiInCEofc, smiInCData, input smiInCStop,
    output smiInDReady, smiInDEofc, smiInDData, input smiInDStop,
    input  smiOutReady, smiOutEofc, smiOutData, output smiOutStop,
    input  grantValid, grantPort
  );

  modport slave (
    input  weightA, weightB, weightC, weightD,
    input  smiInAReady, smiInAEofc, smiInAData, output smiInAStop,
    input  smiInBReady, smiInBEofc, smiInBData, output smiInBStop,
    input  smiInCReady, smiInCEofc, smiInCData, output smiInCStop,
    input  smiInDReady, smiInDEofc, smiInDData, output smiInDStop,
    output smiOutReady, smiOutEofc, smiOutData, input smiOutStop,
    output grantValid, grantPort
  );
endinterface

// File: rtl/smi_frame_wrr_scheduler_x4.sv
// ---------------------------------------------------------------------------
// smi_frame_wrr_scheduler_x4
// Shares one registered SMI output link between four SMI input ports.  A
// grant lets the owning port send up to weight (0 counts as 1) whole frames;
// frames are never interleaved.  The next owner is found by a rotating
// first-ready search, and a release hands over to the next requester in the
// same cycle so the output sees no bubble.
// Ports:
//   clk  : clock, rising edge
//   arst : asynchronous active-high reset
//   bus  : slave side of smi_frame_wrr_scheduler_x4_if (inputs A..D,
//          shared output, per-port weights, grant status)
// ---------------------------------------------------------------------------
module smi_frame_wrr_scheduler_x4 #(
  parameter int         FlitWidth   = 2,
  parameter int         WeightWidth = 4,
  parameter logic [7:0] EofcMask    = 8'(2*FlitWidth-1)
) (
  input logic clk,
  input logic arst,
  smi_frame_wrr_scheduler_x4_if.slave bus
);
  localparam int DW = FlitWidth*8;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                 r_state;
  logic [1:0]             r_cur;
  logic [1:0]             r_ptr;
  logic [WeightWidth-1:0] r_credit;
  logic                   r_mid;
  logic                   r_out_ready;
  logic [7:0]             r_out_eofc;
  logic [DW-1:0]          r_out_data;

  logic [3:0]             w_ready;
  logic [7:0]             w_eofc   [4];
  logic [DW-1:0]          w_data   [4];
  logic [WeightWidth-1:0] w_weight [4];
  logic                   w_granted;
  logic                   w_load;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [1:0]             w_start;
  logic [2:0]             w_search;

  // First requesting port scanning start, start+1, ... (mod 4); {hit, port}.
  function automatic logic [2:0] find_next(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Scan from the far end so the nearest requester is written last and wins.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Fresh credit for a new grant; a zero weight still allows one frame.
  function automatic logic [WeightWidth-1:0] load_credit(input logic [WeightWidth-1:0] w);
    return (w == '0) ? WeightWidth'(1'b1) : w;
  endfunction

  // Gather the per-port inputs into indexable arrays.
  always_comb begin
    w_ready     = {bus.smiInDReady, bus.smiInCReady, bus.smiInBReady, bus.smiInAReady};
    w_eofc[0]   = bus.smiInAEofc;
    w_eofc[1]   = bus.smiInBEofc;
    w_eofc[2]   = bus.smiInCEofc;
    w_eofc[3]   = bus.smiInDEofc;
    w_data[0]   = bus.smiInAData;
    w_data[1]   = bus.smiInBData;
    w_data[2]   = bus.smiInCData;
    w_data[3]   = bus.smiInDData;
    w_weight[0] = bus.weightA;
    w_weight[1] = bus.weightB;
    w_weight[2] = bus.weightC;
    w_weight[3] = bus.weightD;
  end

  // Transfer, release and next-owner decisions for this cycle.
  always_comb begin
    w_granted = (r_state == S_GRANT);
    w_load    = ~(r_out_ready & bus.smiOutStop);
    w_accept  = w_granted & w_ready[r_cur] & w_load;
    w_last    = w_accept & (w_eofc[r_cur] != 8'h00);
    // Release after the final credited frame, or when the owner is idle between frames.
    w_release = w_granted & ((w_last & (r_credit == WeightWidth'(1'b1))) |
                             (~r_mid & ~w_ready[r_cur]));
    if (w_granted) begin
      w_start = r_cur + 2'd1;
    end else begin
      w_start = r_ptr;
    end
    w_search = find_next(w_ready, w_start);
  end

  // Only the owner may be let through, and only while the output can load.
  always_comb begin
    bus.smiInAStop = ~(w_granted & (r_cur == 2'd0)) | ~w_load;
    bus.smiInBStop = ~(w_granted & (r_cur == 2'd1)) | ~w_load;
    bus.smiInCStop = ~(w_granted & (r_cur == 2'd2)) | ~w_load;
    bus.smiInDStop = ~(w_granted & (r_cur == 2'd3)) | ~w_load;
    bus.smiOutReady = r_out_ready;
    bus.smiOutEofc  = r_out_eofc;
    bus.smiOutData  = r_out_data;
    bus.grantValid  = (r_state == S_GRANT);
    bus.grantPort   = r_cur;
  end

  // Output register and grant state machine.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_cur       <= 2'd0;
      r_ptr       <= 2'd0;
      r_credit    <= '0;
      r_mid       <= 1'b0;
      r_out_ready <= 1'b0;
      r_out_eofc  <= 8'h00;
      r_out_data  <= '0;
    end else begin
      if (w_load) begin
        r_out_ready <= w_accept;
        r_out_eofc  <= w_granted ? (w_eofc[r_cur] & EofcMask) : 8'h00;
        r_out_data  <= w_granted ? w_data[r_cur] : '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_search[2]) begin
            r_state  <= S_GRANT;
            r_cur    <= w_search[1:0];
            r_credit <= load_credit(w_weight[w_search[1:0]]);
            r_mid    <= 1'b0;
          end
        end
        S_GRANT: begin
          if (w_accept) begin
            if (w_last) begin
              r_mid    <= 1'b0;
              r_credit <= r_credit - WeightWidth'(1'b1);
            end else begin
              r_mid <= 1'b1;
            end
          end
          // A release overrides the bookkeeping above with the new owner's state.
          if (w_release) begin
            r_ptr <= r_cur + 2'd1;
            if (w_search[2]) begin
              r_cur    <= w_search[1:0];
              r_credit <= load_credit(w_weight[w_search[1:0]]);
              r_mid    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_mid   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_smi_frame_wrr_scheduler_x4.sv
// ---------------------------------------------------------------------------
// tb_smi_frame_wrr_scheduler_x4
// Directed bench for the four-port weighted round-robin frame scheduler.
// Per-port flit queues act as SMI sources; the shared output is always
// accepted unless a step lowers it explicitly.
// ---------------------------------------------------------------------------
module tb_smi_frame_wrr_scheduler_x4;
  localparam int FW = 2;
  localparam int WW = 4;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  always #5 clk = ~clk;

  smi_frame_wrr_scheduler_x4_if #(.FlitWidth(FW), .WeightWidth(WW)) bus ();

  smi_frame_wrr_scheduler_x4 #(.FlitWidth(FW), .WeightWidth(WW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  // Entry: bit 24 = bubble (Ready held low one cycle), [23:16] eofc, [15:0] data.
  logic [24:0] q [4][$];
  logic [23:0] olog [$];
  int          ocyc [$];
  int          acc_cyc [int];
  int          last_acc [4];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fd(input int p, input int f, input int i);
    return {4'(10 + p), 4'(f), 8'(i)};
  endfunction

  task automatic set_port(input int p, input logic r, input logic [7:0] e, input logic [15:0] d);
    case (p)
      0: begin bus.smiInAReady = r; bus.smiInAEofc = e; bus.smiInAData = d; end
      1: begin bus.smiInBReady = r; bus.smiInBEofc = e; bus.smiInBData = d; end
      2: begin bus.smiInCReady = r; bus.smiInCEofc = e; bus.smiInCData = d; end
      default: begin bus.smiInDReady = r; bus.smiInDEofc = e; bus.smiInDData = d; end
    endcase
  endtask

  function automatic logic get_ready(input int p);
    case (p)
      0: return bus.smiInAReady;
      1: return bus.smiInBReady;
      2: return bus.smiInCReady;
      default: return bus.smiInDReady;
    endcase
  endfunction

  function automatic logic get_stop(input int p);
    case (p)
      0: return bus.smiInAStop;
      1: return bus.smiInBStop;
      2: return bus.smiInCStop;
      default: return bus.smiInDStop;
    endcase
  endfunction

  task automatic drive_inputs();
    for (int p = 0; p < 4; p++) begin
      if (q[p].size() > 0 && q[p][0][24] == 1'b0) begin
        set_port(p, 1'b1, q[p][0][23:16], q[p][0][15:0]);
      end else begin
        set_port(p, 1'b0, 8'h00, 16'h0000);
      end
    end
  endtask

  task automatic push_frame(input int p, input int f, input int n, input logic [7:0] last_e);
    for (int i = 0; i < n; i++) begin
      q[p].push_back({1'b0, (i == n - 1) ? last_e : 8'h00, fd(p, f, i)});
    end
  endtask

  // One clock: sample handshakes before the edge, update sources after it.
  task automatic step();
    logic [3:0]  acc;
    logic        ofire;
    logic [23:0] oval;
    #1;
    for (int p = 0; p < 4; p++) acc[p] = get_ready(p) & ~get_stop(p);
    ofire = bus.smiOutReady & ~bus.smiOutStop;
    oval  = {bus.smiOutEofc, bus.smiOutData};
    @(posedge clk);
    cyc++;
    for (int p = 0; p < 4; p++) begin
      if (q[p].size() > 0) begin
        if (acc[p]) begin
          acc_cyc[int'(q[p][0][15:0])] = cyc;
          last_acc[p] = cyc;
          void'(q[p].pop_front());
        end else if (q[p][0][24]) begin
          void'(q[p].pop_front());
        end
      end
    end
    if (ofire) begin
      olog.push_back(oval);
      ocyc.push_back(cyc);
    end
    #1;
    drive_inputs();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    for (int p = 0; p < 4; p++) q[p].delete();
    drive_inputs();
    bus.smiOutStop = 1'b0;
    bus.weightA = 4'd1; bus.weightB = 4'd1; bus.weightC = 4'd1; bus.weightD = 4'd1;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
    olog.delete();
    ocyc.delete();
    acc_cyc.delete();
    last_acc = '{-100, -100, -100, -100};
    cyc = 0;
  endtask

  initial begin
    int          ord [14];
    int          fc [4];
    logic [23:0] exp_q [$];
    logic [15:0] d;
    int          seen;

    for (int p = 0; p < 4; p++) q[p].delete();
    drive_inputs();
    bus.smiOutStop = 1'b0;
    bus.weightA = 4'd1; bus.weightB = 4'd1; bus.weightC = 4'd1; bus.weightD = 4'd1;
    #1;
    chk("rst_out_ready", 32'(bus.smiOutReady), 32'd0);
    chk("rst_out_eofc", 32'(bus.smiOutEofc), 32'd0);
    chk("rst_out_data", 32'(bus.smiOutData), 32'd0);
    chk("rst_stops", 32'({bus.smiInDStop, bus.smiInCStop, bus.smiInBStop, bus.smiInAStop}), 32'hF);
    chk("rst_grant_valid", 32'(bus.grantValid), 32'd0);
    chk("rst_grant_port", 32'(bus.grantPort), 32'd0);

    // Port A alone, weight 1, three 4-flit frames; last eofc FE masks to 02.
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(0, f, 4, 8'hFE);
    drive_inputs();
    for (int k = 0; k < 60 && olog.size() < 12; k++) step();
    chk("s1_count", 32'(olog.size()), 32'd12);
    for (int i = 0; i < olog.size() && i < 12; i++) begin
      d = fd(0, i / 4, i % 4);
      chk("s1_flit", 32'(olog[i]), 32'({((i % 4) == 3) ? 8'h02 : 8'h00, d}));
      chk("s1_latency", 32'(ocyc[i]), 32'(acc_cyc[int'(d)] + 1));
      chk("s1_no_gap", 32'(ocyc[i]), 32'(ocyc[0] + i));
    end
    for (int k = 0; k < 5; k++) step();
    chk("s1_idle_after", 32'(bus.grantValid), 32'd0);

    // All four ports busy, weights 3/1/2/1, 2-flit frames: AAA B CC D twice.
    do_reset();
    bus.weightA = 4'd3; bus.weightB = 4'd1; bus.weightC = 4'd2; bus.weightD = 4'd1;
    for (int f = 0; f < 6; f++) push_frame(0, f, 2, 8'h01);
    for (int f = 0; f < 2; f++) push_frame(1, f, 2, 8'h01);
    for (int f = 0; f < 4; f++) push_frame(2, f, 2, 8'h01);
    for (int f = 0; f < 2; f++) push_frame(3, f, 2, 8'h01);
    drive_inputs();
    for (int k = 0; k < 150 && olog.size() < 28; k++) step();
    ord = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
    fc  = '{0, 0, 0, 0};
    exp_q.delete();
    for (int fr = 0; fr < 14; fr++) begin
      for (int i = 0; i < 2; i++) exp_q.push_back({(i == 1) ? 8'h01 : 8'h00, fd(ord[fr], fc[ord[fr]], i)});
      fc[ord[fr]]++;
    end
    chk("s2_count", 32'(olog.size()), 32'd28);
    for (int i = 0; i < olog.size() && i < 28; i++) begin
      chk("s2_order", 32'(olog[i]), 32'(exp_q[i]));
      chk("s2_no_gap", 32'(ocyc[i]), 32'(ocyc[0] + i));
    end

    // Output stall toggled every other cycle during a 5-flit frame from B.
    do_reset();
    push_frame(1, 0, 5, 8'h01);
    drive_inputs();
    for (int k = 0; k < 40 && olog.size() < 5; k++) begin
      bus.smiOutStop = ((k % 2) == 1);
      #1;
      if (q[1].size() >= 1 && q[1].size() <= 4) begin
        chk("s3_stop_mirror", 32'(bus.smiInBStop), 32'(bus.smiOutReady & bus.smiOutStop));
      end
      step();
    end
    bus.smiOutStop = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("s3_count_once", 32'(olog.size()), 32'd5);
    for (int i = 0; i < olog.size() && i < 5; i++) begin
      chk("s3_order", 32'(olog[i]), 32'({(i == 4) ? 8'h01 : 8'h00, fd(1, 0, i)}));
    end

    // C frame with a 3-cycle Ready gap while D requests; weights 0 act as 1.
    do_reset();
    bus.weightC = 4'd0; bus.weightD = 4'd0;
    q[2].push_back({1'b0, 8'h00, fd(2, 0, 0)});
    q[2].push_back({1'b0, 8'h00, fd(2, 0, 1)});
    for (int i = 0; i < 3; i++) q[2].push_back({1'b1, 8'h00, 16'h0000});
    q[2].push_back({1'b0, 8'h01, fd(2, 0, 2)});
    push_frame(3, 0, 2, 8'h01);
    drive_inputs();
    for (int k = 0; k < 40 && olog.size() < 5; k++) begin
      step();
      if (q[2].size() >= 1 && q[2].size() <= 5) begin
        chk("s4_hold_valid", 32'(bus.grantValid), 32'd1);
        chk("s4_hold_port", 32'(bus.grantPort), 32'd2);
      end
    end
    chk("s4_handoff", 32'(acc_cyc[int'(fd(3, 0, 0))]), 32'(last_acc[2] + 1));
    chk("s4_count", 32'(olog.size()), 32'd5);
    exp_q = '{{8'h00, fd(2, 0, 0)}, {8'h00, fd(2, 0, 1)}, {8'h01, fd(2, 0, 2)},
              {8'h00, fd(3, 0, 0)}, {8'h01, fd(3, 0, 1)}};
    for (int i = 0; i < olog.size() && i < 5; i++) chk("s4_order", 32'(olog[i]), 32'(exp_q[i]));

    // A (weight 4) sends one frame then goes idle; B takes over.
    do_reset();
    bus.weightA = 4'd4; bus.weightB = 4'd1;
    push_frame(0, 0, 2, 8'h01);
    push_frame(1, 0, 2, 8'h01);
    drive_inputs();
    seen = 0;
    for (int k = 0; k < 40 && olog.size() < 4; k++) begin
      step();
      if (cyc == last_acc[0] + 1) begin
        seen = 1;
        chk("s5_grant_valid", 32'(bus.grantValid), 32'd1);
        chk("s5_grant_b", 32'(bus.grantPort), 32'd1);
      end
    end
    chk("s5_grant_seen", 32'(seen), 32'd1);
    chk("s5_b_start", 32'(acc_cyc[int'(fd(1, 0, 0))]), 32'(last_acc[0] + 2));
    chk("s5_count", 32'(olog.size()), 32'd4);

    // Reset in the middle of a D frame, then arbitration restarts at A.
    do_reset();
    push_frame(3, 0, 4, 8'h01);
    drive_inputs();
    for (int k = 0; k < 20 && q[3].size() > 2; k++) step();
    chk("s6_mid_frame", 32'(q[3].size()), 32'd2);
    #2;
    arst = 1'b1;
    #1;
    chk("s6_out_ready", 32'(bus.smiOutReady), 32'd0);
    chk("s6_out_data", 32'(bus.smiOutData), 32'd0);
    chk("s6_stops", 32'({bus.smiInDStop, bus.smiInCStop, bus.smiInBStop, bus.smiInAStop}), 32'hF);
    chk("s6_grant_valid", 32'(bus.grantValid), 32'd0);
    do_reset();
    push_frame(3, 1, 2, 8'h01);
    push_frame(0, 0, 2, 8'h01);
    drive_inputs();
    for (int k = 0; k < 40 && olog.size() < 4; k++) step();
    chk("s6_count", 32'(olog.size()), 32'd4);
    if (olog.size() >= 4) begin
      chk("s6_first_a", 32'(olog[0]), 32'({8'h00, fd(0, 0, 0)}));
      chk("s6_then_d", 32'(olog[2]), 32'({8'h00, fd(3, 1, 0)}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
